// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing for the pipeline hazard controller.
// Register-file geometry and controller state encoding.
package pipe_ctrl_pkg;

  localparam int NREG  = 8;
  localparam int REG_W = 3;
  localparam int CNT_W = 2;

  localparam logic [CNT_W-1:0] MAX_INFLIGHT = CNT_W'(3);

  typedef enum logic [1:0] {
    RUN,
    BR_WAIT,
    DRAIN,
    HALTED
  } state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with decode lookups.
// all_zero reflects the counts after this cycle's update.
module reg_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [REG_W-1:0] inc_rd,
  input  logic             dec,
  input  logic [REG_W-1:0] dec_rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rq,
  input  logic [REG_W-1:0] rd,
  output logic             rs_busy,
  output logic             rq_busy,
  output logic             rd_full,
  output logic             all_zero,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt     [NREG];
  logic [CNT_W-1:0] cnt_nxt [NREG];

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      logic inc_i;
      logic dec_i;
      inc_i = inc && (inc_rd == REG_W'(i));
      dec_i = dec && (dec_rd == REG_W'(i));
      cnt_nxt[i] = cnt[i];
      if (inc_i && !dec_i && cnt[i] != MAX_INFLIGHT)
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      else if (dec_i && !inc_i && cnt[i] != '0)
        cnt_nxt[i] = cnt[i] - CNT_W'(1);
      if (cnt_nxt[i] != '0)
        all_zero = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        cnt[i] <= cnt_nxt[i];
    end
  end

  assign rs_busy   = cnt[rs] != '0;
  assign rq_busy   = cnt[rq] != '0;
  assign rd_full   = cnt[rd] == MAX_INFLIGHT;
  assign underflow = dec && (cnt[dec_rd] == '0);

endmodule

// File: rtl/pipeline_ctrl.sv
// Decode-side hazard, branch-hold and halt sequencing control.
// Stall/bubble/flush are combinational; state and errors registered.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [REG_W-1:0] dec_rs,
  input  logic             dec_rs_used,
  input  logic [REG_W-1:0] dec_rq,
  input  logic             dec_rq_used,
  input  logic [REG_W-1:0] dec_rd,
  input  logic             dec_write_en,
  input  logic             dec_is_branch,
  input  logic             dec_halt,
  input  logic             ex_br_resolved,
  input  logic             ex_br_taken,
  input  logic             wb_write_en,
  input  logic [REG_W-1:0] wb_rd,
  output logic             stall_fd,
  output logic             bubble_de,
  output logic             flush_fd,
  output logic             halted,
  output logic             sb_err
);

  state_t state;
  state_t state_nxt;

  logic rs_busy;
  logic rq_busy;
  logic rd_full;
  logic all_zero;
  logic underflow;
  logic hazard;
  logic issue;
  logic stall_c;
  logic bubble_c;
  logic flush_c;

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .inc       (issue & dec_write_en),
    .inc_rd    (dec_rd),
    .dec       (wb_write_en),
    .dec_rd    (wb_rd),
    .rs        (dec_rs),
    .rq        (dec_rq),
    .rd        (dec_rd),
    .rs_busy   (rs_busy),
    .rq_busy   (rq_busy),
    .rd_full   (rd_full),
    .all_zero  (all_zero),
    .underflow (underflow)
  );

  assign hazard = (dec_rs_used & rs_busy)
                | (dec_rq_used & rq_busy)
                | (dec_write_en & rd_full);

  assign issue = dec_valid & (state == RUN) & ~hazard;

  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    unique case (state)
      RUN: begin
        stall_c  = dec_valid & hazard;
        bubble_c = dec_valid & hazard;
        if (issue && dec_halt)
          state_nxt = DRAIN;
        else if (issue && dec_is_branch)
          state_nxt = BR_WAIT;
      end
      BR_WAIT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (ex_br_resolved) begin
          state_nxt = RUN;
          // Let the target fetch through while the wrong path is dropped
          if (ex_br_taken) begin
            flush_c = 1'b1;
            stall_c = 1'b0;
          end
        end
      end
      DRAIN: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (all_zero)
          state_nxt = HALTED;
      end
      HALTED: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign stall_fd  = stall_c & ~rst;
  assign bubble_de = bubble_c & ~rst;
  assign flush_fd  = flush_c & ~rst;
  assign halted    = state == HALTED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      sb_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (underflow || (ex_br_resolved && state != BR_WAIT))
        sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector bench for pipeline_ctrl.
// Inputs change on negedge; outputs sampled 1ns later, before posedge.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       dec_valid;
  logic [2:0] dec_rs;
  logic       dec_rs_used;
  logic [2:0] dec_rq;
  logic       dec_rq_used;
  logic [2:0] dec_rd;
  logic       dec_write_en;
  logic       dec_is_branch;
  logic       dec_halt;
  logic       ex_br_resolved;
  logic       ex_br_taken;
  logic       wb_write_en;
  logic [2:0] wb_rd;
  logic       stall_fd;
  logic       bubble_de;
  logic       flush_fd;
  logic       halted;
  logic       sb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .dec_valid      (dec_valid),
    .dec_rs         (dec_rs),
    .dec_rs_used    (dec_rs_used),
    .dec_rq         (dec_rq),
    .dec_rq_used    (dec_rq_used),
    .dec_rd         (dec_rd),
    .dec_write_en   (dec_write_en),
    .dec_is_branch  (dec_is_branch),
    .dec_halt       (dec_halt),
    .ex_br_resolved (ex_br_resolved),
    .ex_br_taken    (ex_br_taken),
    .wb_write_en    (wb_write_en),
    .wb_rd          (wb_rd),
    .stall_fd       (stall_fd),
    .bubble_de      (bubble_de),
    .flush_fd       (flush_fd),
    .halted         (halted),
    .sb_err         (sb_err)
  );

  typedef struct {
    string      name;
    logic       valid;
    logic [2:0] rs;
    logic       rsu;
    logic [2:0] rq;
    logic       rqu;
    logic [2:0] rd;
    logic       we;
    logic       br;
    logic       hlt;
    logic       res;
    logic       tkn;
    logic       wbe;
    logic [2:0] wbrd;
    logic       e_stall;
    logic       e_bub;
    logic       e_flush;
    logic       e_halt;
    logic       e_err;
  } vec_t;

  vec_t vt [$];

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    dec_valid = 0; dec_rs = 0; dec_rs_used = 0;
    dec_rq = 0; dec_rq_used = 0; dec_rd = 0;
    dec_write_en = 0; dec_is_branch = 0; dec_halt = 0;
    ex_br_resolved = 0; ex_br_taken = 0;
    wb_write_en = 0; wb_rd = 0;
  endtask

  task automatic drive(input vec_t v);
    dec_valid = v.valid; dec_rs = v.rs; dec_rs_used = v.rsu;
    dec_rq = v.rq; dec_rq_used = v.rqu; dec_rd = v.rd;
    dec_write_en = v.we; dec_is_branch = v.br; dec_halt = v.hlt;
    ex_br_resolved = v.res; ex_br_taken = v.tkn;
    wb_write_en = v.wbe; wb_rd = v.wbrd;
  endtask

  task automatic check_all(input string nm, input logic s,
                           input logic b, input logic f,
                           input logic h, input logic e);
    chk({nm, ".stall"},  stall_fd,  s);
    chk({nm, ".bubble"}, bubble_de, b);
    chk({nm, ".flush"},  flush_fd,  f);
    chk({nm, ".halted"}, halted,    h);
    chk({nm, ".sb_err"}, sb_err,    e);
  endtask

  // name valid rs rsu rq rqu rd we br hlt res tkn wbe wbrd | s b f h e
  task automatic add(input string nm, input logic va,
                     input logic [2:0] rs, input logic rsu,
                     input logic [2:0] rq, input logic rqu,
                     input logic [2:0] rd, input logic we,
                     input logic br, input logic hl,
                     input logic rs_, input logic tk,
                     input logic wbe, input logic [2:0] wrd,
                     input logic s, input logic b, input logic f,
                     input logic h, input logic e);
    vec_t v;
    v = '{nm, va, rs, rsu, rq, rqu, rd, we, br, hl, rs_, tk,
          wbe, wrd, s, b, f, h, e};
    vt.push_back(v);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    #1;
    check_all("in_reset", 0, 0, 0, 0, 0);

    add("idle",     0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r3",    1,0,0,0,0,3,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("raw_r3",   1,3,1,0,0,0,0,0,0,0,0,1,3, 1,1,0,0,0);
    add("raw_gone", 1,3,1,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r2",    1,0,0,0,0,2,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r2_wb", 1,0,0,0,0,2,1,0,0,0,0,1,2, 0,0,0,0,0);
    add("rq_r2",    1,0,0,2,1,0,0,0,0,0,0,1,2, 1,1,0,0,0);
    add("rq_r2_ok", 1,0,0,2,1,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r5_a",  1,0,0,0,0,5,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r5_b",  1,0,0,0,0,5,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r5_c",  1,0,0,0,0,5,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r5_sat",1,0,0,0,0,5,1,0,0,0,0,0,0, 1,1,0,0,0);
    add("sat_wb",   1,0,0,0,0,5,1,0,0,0,0,1,5, 1,1,0,0,0);
    add("sat_iss",  1,0,0,0,0,5,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("ret_r5_a", 0,0,0,0,0,0,0,0,0,0,0,1,5, 0,0,0,0,0);
    add("ret_r5_b", 0,0,0,0,0,0,0,0,0,0,0,1,5, 0,0,0,0,0);
    add("ret_r5_c", 0,0,0,0,0,0,0,0,0,0,0,1,5, 0,0,0,0,0);
    add("br_t",     1,0,0,0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0);
    add("br_t_wait",1,0,0,0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0);
    add("br_t_res", 1,0,0,0,0,0,0,0,0,1,1,0,0, 0,1,1,0,0);
    add("br_t_run", 1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    add("br_n",     1,0,0,0,0,0,0,1,0,0,0,0,0, 0,0,0,0,0);
    add("br_n_res", 1,0,0,0,0,0,0,0,0,1,0,0,0, 1,1,0,0,0);
    add("br_n_run", 1,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r1",    1,0,0,0,0,1,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("wr_r4",    1,0,0,0,0,4,1,0,0,0,0,0,0, 0,0,0,0,0);
    add("halt_iss", 1,0,0,0,0,0,0,1,1,0,0,0,0, 0,0,0,0,0);
    add("drain_0",  0,0,0,0,0,0,0,0,0,0,0,0,0, 1,1,0,0,0);
    add("drain_r1", 0,0,0,0,0,0,0,0,0,0,0,1,1, 1,1,0,0,0);
    add("drain_r4", 1,0,0,0,0,0,0,0,0,0,0,1,4, 1,1,0,0,0);
    add("halted_1", 0,0,0,0,0,0,0,0,0,0,0,0,0, 1,1,0,1,0);

    cyc();
    rst = 1'b0;
    foreach (vt[i]) begin
      cyc();
      drive(vt[i]);
      #1;
      check_all(vt[i].name, vt[i].e_stall, vt[i].e_bub,
                vt[i].e_flush, vt[i].e_halt, vt[i].e_err);
    end

    for (int i = 0; i < 20; i++) begin
      cyc();
      idle_in();
      dec_valid = (i % 2) == 0;
      #1;
      chk("halt_hold.halted", halted, 1'b1);
      chk("halt_hold.stall", stall_fd, 1'b1);
    end

    // reset while halted
    cyc();
    rst = 1'b1;
    #1;
    check_all("rst_halted", 0, 0, 0, 0, 0);

    // reset mid-drain
    cyc();
    rst = 1'b0;
    idle_in();
    dec_valid = 1; dec_rd = 1; dec_write_en = 1;
    cyc();
    idle_in();
    dec_valid = 1; dec_halt = 1;
    cyc();
    idle_in();
    dec_valid = 1; dec_rs = 1; dec_rs_used = 1;
    #1;
    check_all("drain_pend", 1, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_drain", 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    #1;
    check_all("post_rst_rd_r1", 0, 0, 0, 0, 0);

    // reset mid-branch
    cyc();
    idle_in();
    dec_valid = 1; dec_is_branch = 1;
    cyc();
    idle_in();
    dec_valid = 1;
    #1;
    chk("br_hold.stall", stall_fd, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("rst_branch", 0, 0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    #1;
    check_all("post_rst_br", 0, 0, 0, 0, 0);

    // underflow on R7
    cyc();
    idle_in();
    wb_write_en = 1; wb_rd = 7;
    #1;
    chk("uf_pre.sb_err", sb_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      idle_in();
      #1;
      chk("uf_sticky.sb_err", sb_err, 1'b1);
    end
    cyc();
    rst = 1'b1;
    #1;
    chk("uf_rst.sb_err", sb_err, 1'b0);

    // resolve outside BR_WAIT
    cyc();
    rst = 1'b0;
    idle_in();
    ex_br_resolved = 1; ex_br_taken = 1;
    #1;
    chk("stray_res.flush", flush_fd, 1'b0);
    chk("stray_res.stall", stall_fd, 1'b0);
    cyc();
    idle_in();
    #1;
    chk("stray_res.sb_err", sb_err, 1'b1);
    chk("stray_res.halted", halted, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
